// File: rtl/srv_retire_trace_buf.sv
// srv_retire_trace_buf: captures up to two retired instructions per cycle (i0 older than i1),
// keeps them in program order in a register FIFO, and drains one per cycle over a valid/ready
// trace port. It never stalls the core: retires that do not fit are dropped and counted.
// Optional build macro: SRV_TRACE_TIMESTAMP_EN adds a per-entry 32-bit cycle stamp (trace_cycle).
module srv_retire_trace_buf #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_clr,
  input  logic              rtu_i0_vld,
  input  logic [31:0]       rtu_i0_pc,
  input  logic              rtu_i0_rd_wen,
  input  logic [4:0]        rtu_i0_rd_idx,
  input  logic [31:0]       rtu_i0_rd_data,
  input  logic              rtu_i1_vld,
  input  logic [31:0]       rtu_i1_pc,
  input  logic              rtu_i1_rd_wen,
  input  logic [4:0]        rtu_i1_rd_idx,
  input  logic [31:0]       rtu_i1_rd_data,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic              trace_rd_wen,
  output logic [4:0]        trace_rd_idx,
  output logic [31:0]       trace_rd_data,
`ifdef SRV_TRACE_TIMESTAMP_EN
  output logic [31:0]       trace_cycle,
`endif
  output logic              trace_ovf,
  output logic [DROP_W-1:0] trace_drop_cnt,
  output logic [31:0]       trace_ret_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // One FIFO entry; the stamp field only exists in the timestamp build.
  typedef struct packed {
`ifdef SRV_TRACE_TIMESTAMP_EN
    logic [31:0] cycle;
`endif
    logic [31:0] pc;
    logic        rd_wen;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count;
  logic [PW-1:0] wptr_p1;
  logic          full;
  logic          room2;
  logic [1:0]    n_vld;
  logic [1:0]    n_store;
  logic [1:0]    n_drop;
  logic          pop;
  entry_t        slot0;
  entry_t        slot1;
  entry_t        ent_a;
  entry_t        ent_b;
  entry_t        head;
  logic [DROP_W:0] drop_sum;
  logic [DROP_W-1:0] drop_next;

`ifdef SRV_TRACE_TIMESTAMP_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter stamped into every entry pushed this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (trace_clr) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

  // Occupancy is derived from the registered pointers only, so a pop this
  // cycle never makes room for this cycle's push.
  always_comb begin
    count   = wptr - rptr;
    wptr_p1 = wptr + PW'(1);
    full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    room2   = (count <= PW'(DEPTH - 2));
    pop     = trace_valid && trace_ready;
  end

  // Pack each retire slot into an entry; both slots of a cycle share the stamp.
  always_comb begin
    slot0         = '0;
    slot1         = '0;
    slot0.pc      = rtu_i0_pc;
    slot0.rd_wen  = rtu_i0_rd_wen;
    slot0.rd_idx  = rtu_i0_rd_idx;
    slot0.rd_data = rtu_i0_rd_data;
    slot1.pc      = rtu_i1_pc;
    slot1.rd_wen  = rtu_i1_rd_wen;
    slot1.rd_idx  = rtu_i1_rd_idx;
    slot1.rd_data = rtu_i1_rd_data;
`ifdef SRV_TRACE_TIMESTAMP_EN
    slot0.cycle   = cyc_cnt;
    slot1.cycle   = cyc_cnt;
`endif
  end

  // Compact valid slots in program order: the oldest valid slot always goes
  // to wptr, the second (only when both are valid) to wptr+1.
  always_comb begin
    ent_a = rtu_i0_vld ? slot0 : slot1;
    ent_b = slot1;
  end

  // Decide how many slots fit; with one free entry only the older survives.
  always_comb begin
    n_vld   = {1'b0, rtu_i0_vld} + {1'b0, rtu_i1_vld};
    n_store = 2'd0;
    if (full) begin
      n_store = 2'd0;
    end else if (!room2) begin
      n_store = (n_vld != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      n_store = n_vld;
    end
    n_drop = n_vld - n_store;
  end

  // Saturating add for the drop counter.
  always_comb begin
    drop_sum  = {1'b0, trace_drop_cnt} + (DROP_W + 1)'(n_drop);
    drop_next = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Storage array: no reset needed, every output read is gated by occupancy.
  always_ff @(posedge clk) begin
    if (!trace_clr) begin
      if (n_store != 2'd0) begin
        mem[wptr[AW-1:0]] <= ent_a;
      end
      if (n_store == 2'd2) begin
        mem[wptr_p1[AW-1:0]] <= ent_b;
      end
    end
  end

  // Pointers: clear wins over push/pop; otherwise push and pop both apply.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (trace_clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(n_store);
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  // Statistics: sticky overflow, saturating drop count, wrapping retire count.
  // Retires discarded by a clear are neither stored nor counted as drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_ovf      <= 1'b0;
      trace_drop_cnt <= '0;
      trace_ret_cnt  <= '0;
    end else if (trace_clr) begin
      trace_ovf      <= 1'b0;
      trace_drop_cnt <= '0;
      trace_ret_cnt  <= '0;
    end else begin
      if (n_drop != 2'd0) begin
        trace_ovf      <= 1'b1;
        trace_drop_cnt <= drop_next;
      end
      trace_ret_cnt <= trace_ret_cnt + 32'(n_store);
    end
  end

  // Head of FIFO drives the trace port; fields read as zero while empty.
  // The head slot is never written while occupied, so it holds under stall.
  always_comb begin
    head          = mem[rptr[AW-1:0]];
    trace_valid   = (count != '0);
    trace_pc      = trace_valid ? head.pc      : 32'd0;
    trace_rd_wen  = trace_valid ? head.rd_wen  : 1'b0;
    trace_rd_idx  = trace_valid ? head.rd_idx  : 5'd0;
    trace_rd_data = trace_valid ? head.rd_data : 32'd0;
`ifdef SRV_TRACE_TIMESTAMP_EN
    trace_cycle   = trace_valid ? head.cycle   : 32'd0;
`endif
  end

endmodule

// File: tb/tb_srv_retire_trace_buf.sv
// Directed bench for srv_retire_trace_buf (DEPTH=8, DROP_W=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Define SRV_TRACE_TIMESTAMP_EN for both files to exercise the cycle stamp.
module tb_srv_retire_trace_buf;

  logic        clk;
  logic        reset;
  logic        trace_clr;
  logic        rtu_i0_vld;
  logic [31:0] rtu_i0_pc;
  logic        rtu_i0_rd_wen;
  logic [4:0]  rtu_i0_rd_idx;
  logic [31:0] rtu_i0_rd_data;
  logic        rtu_i1_vld;
  logic [31:0] rtu_i1_pc;
  logic        rtu_i1_rd_wen;
  logic [4:0]  rtu_i1_rd_idx;
  logic [31:0] rtu_i1_rd_data;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic        trace_rd_wen;
  logic [4:0]  trace_rd_idx;
  logic [31:0] trace_rd_data;
`ifdef SRV_TRACE_TIMESTAMP_EN
  logic [31:0] trace_cycle;
`endif
  logic        trace_ovf;
  logic [15:0] trace_drop_cnt;
  logic [31:0] trace_ret_cnt;

  int checks;
  int errors;

  srv_retire_trace_buf #(.DEPTH(8), .DROP_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .trace_clr      (trace_clr),
    .rtu_i0_vld     (rtu_i0_vld),
    .rtu_i0_pc      (rtu_i0_pc),
    .rtu_i0_rd_wen  (rtu_i0_rd_wen),
    .rtu_i0_rd_idx  (rtu_i0_rd_idx),
    .rtu_i0_rd_data (rtu_i0_rd_data),
    .rtu_i1_vld     (rtu_i1_vld),
    .rtu_i1_pc      (rtu_i1_pc),
    .rtu_i1_rd_wen  (rtu_i1_rd_wen),
    .rtu_i1_rd_idx  (rtu_i1_rd_idx),
    .rtu_i1_rd_data (rtu_i1_rd_data),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_rd_wen   (trace_rd_wen),
    .trace_rd_idx   (trace_rd_idx),
    .trace_rd_data  (trace_rd_data),
`ifdef SRV_TRACE_TIMESTAMP_EN
    .trace_cycle    (trace_cycle),
`endif
    .trace_ovf      (trace_ovf),
    .trace_drop_cnt (trace_drop_cnt),
    .trace_ret_cnt  (trace_ret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive both retire slots; rd_data is ~pc so it is distinguishable from pc.
  task automatic drive(input logic v0, input logic [31:0] p0, input logic v1, input logic [31:0] p1);
    rtu_i0_vld     = v0;
    rtu_i0_pc      = p0;
    rtu_i0_rd_wen  = 1'b0;
    rtu_i0_rd_idx  = 5'd0;
    rtu_i0_rd_data = ~p0;
    rtu_i1_vld     = v1;
    rtu_i1_pc      = p1;
    rtu_i1_rd_wen  = 1'b0;
    rtu_i1_rd_idx  = 5'd0;
    rtu_i1_rd_data = ~p1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  int n;

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    trace_clr   = 1'b0;
    trace_ready = 1'b0;
    idle();
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_valid", {31'h0, trace_valid}, 32'h0);
    check("rst_ovf",   {31'h0, trace_ovf},   32'h0);
    check("rst_drop",  {16'h0, trace_drop_cnt}, 32'h0);
    check("rst_ret",   trace_ret_cnt, 32'h0);
    check("rst_pc",    trace_pc, 32'h0);

    // Dual retire, drained in order one per cycle
    trace_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b1, 32'h8000_0004);
    step();
    idle();
    check("dual_head0_pc",   trace_pc, 32'h8000_0000);
    check("dual_head0_data", trace_rd_data, 32'h7fff_ffff);
    step();
    check("dual_head1_pc",   trace_pc, 32'h8000_0004);
    check("dual_head1_vld",  {31'h0, trace_valid}, 32'h1);
    step();
    check("dual_empty_vld",  {31'h0, trace_valid}, 32'h0);
    check("dual_ret",        trace_ret_cnt, 32'd2);

    // Fill with ready low, overflow with a fifth dual retire, then drain
    trace_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000 + 32'(8 * k), 1'b1, 32'h1004 + 32'(8 * k));
      step();
    end
    check("fill_ovf", {31'h0, trace_ovf}, 32'h0);
    drive(1'b1, 32'h1100, 1'b1, 32'h1104);
    step();
    idle();
    check("ovf_set",   {31'h0, trace_ovf}, 32'h1);
    check("ovf_drop",  {16'h0, trace_drop_cnt}, 32'd2);
    check("ovf_ret",   trace_ret_cnt, 32'd10);
    check("stall_pc",  trace_pc, 32'h1000);
    step();
    check("stall_hold_pc", trace_pc, 32'h1000);
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_pc%0d", k), trace_pc, 32'h1000 + 32'(4 * k));
      step();
    end
    check("drain_empty", {31'h0, trace_valid}, 32'h0);

    // Count 7, dual retire with simultaneous pop: older kept, younger dropped
    trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h2000 + 32'(8 * k), 1'b1, 32'h2004 + 32'(8 * k));
      step();
    end
    drive(1'b1, 32'h2018, 1'b0, 32'h0);
    step();
    trace_ready = 1'b1;
    drive(1'b1, 32'h201c, 1'b1, 32'h2020);
    step();
    idle();
    check("c7_drop", {16'h0, trace_drop_cnt}, 32'd3);
    check("c7_ret",  trace_ret_cnt, 32'd18);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (trace_valid) begin
        check($sformatf("c7_pc%0d", n), trace_pc, 32'h2004 + 32'(4 * n));
        n++;
        step();
      end
    end
    check("c7_count", n, 32'd7);

    // i1-only retire carries all of slot 1's fields; clear wipes everything
    trace_ready    = 1'b0;
    idle();
    rtu_i1_vld     = 1'b1;
    rtu_i1_pc      = 32'h8000_0010;
    rtu_i1_rd_wen  = 1'b1;
    rtu_i1_rd_idx  = 5'd5;
    rtu_i1_rd_data = 32'hdead_beef;
    step();
    idle();
    check("i1_vld",  {31'h0, trace_valid}, 32'h1);
    check("i1_pc",   trace_pc, 32'h8000_0010);
    check("i1_wen",  {31'h0, trace_rd_wen}, 32'h1);
    check("i1_idx",  {27'h0, trace_rd_idx}, 32'd5);
    check("i1_data", trace_rd_data, 32'hdead_beef);
    check("i1_ret",  trace_ret_cnt, 32'd19);
    trace_clr = 1'b1;
    drive(1'b1, 32'h3000, 1'b1, 32'h3004);
    step();
    trace_clr = 1'b0;
    idle();
    check("clr_vld",  {31'h0, trace_valid}, 32'h0);
    check("clr_ovf",  {31'h0, trace_ovf}, 32'h0);
    check("clr_drop", {16'h0, trace_drop_cnt}, 32'h0);
    check("clr_ret",  trace_ret_cnt, 32'h0);
    check("clr_data", trace_rd_data, 32'h0);

    // Drop counter saturates at all-ones after 65536 drops
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h4000 + 32'(8 * k), 1'b1, 32'h4004 + 32'(8 * k));
      step();
    end
    drive(1'b1, 32'h5000, 1'b1, 32'h5004);
    for (int k = 0; k < 32768; k++) begin
      step();
    end
    check("sat_drop", {16'h0, trace_drop_cnt}, 32'h0000_ffff);
    step();
    idle();
    check("sat_hold", {16'h0, trace_drop_cnt}, 32'h0000_ffff);
    check("sat_ret",  trace_ret_cnt, 32'd8);

    // Asynchronous reset mid-operation, observed before the next clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_vld",  {31'h0, trace_valid}, 32'h0);
    check("arst_drop", {16'h0, trace_drop_cnt}, 32'h0);
    check("arst_ret",  trace_ret_cnt, 32'h0);
    check("arst_pc",   trace_pc, 32'h0);
    step();
    reset = 1'b0;
    step();
    check("arst_after_vld", {31'h0, trace_valid}, 32'h0);

`ifdef SRV_TRACE_TIMESTAMP_EN
    // Entries retired while the cycle counter reads 100 carry stamp 100
    trace_clr = 1'b1;
    step();
    trace_clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
    end
    drive(1'b1, 32'h6000, 1'b1, 32'h6004);
    step();
    idle();
    check("ts_cyc0", trace_cycle, 32'd100);
    trace_ready = 1'b1;
    step();
    check("ts_cyc1", trace_cycle, 32'd100);
    check("ts_pc1",  trace_pc, 32'h6004);
    step();
    check("ts_empty", trace_cycle, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
